ft_recovery_ctrl: RTL and testbench
===================================

// Module: ft_recovery_ctrl
// PURPOSE
// - Core-side responder to the ft_module lockstep checker. Consumes its halt/shift/resume
//   recovery sequence and drives both cores: halt request, register-file rewrite, PC reload, release.
// - Sits between ft_module outputs and the two cores' debug/register-file/PC write ports.
// PARAMETERS
// - ADDR_WIDTH   5                register-file address width
// - DATA_WIDTH   2**ADDR_WIDTH    register / PC data width
// - TIMEOUT_CYC  64               halt-ack watchdog limit (only used with FT_RECOVERY_TIMEOUT_EN)
// PORTS
// - clk_i          in   1           clock, all logic on rising edge
// - rst_ni         in   1           synchronous reset, active-low
// - halt_i         in   1           recovery start from ft_module
// - shift_i        in   1           addr_i/data_i carry a valid register entry this cycle
// - resume_i       in   1           recovery stream finished
// - addr_i         in   ADDR_WIDTH  register index to restore
// - data_i         in   DATA_WIDTH  register value to restore
// - spc_i          in   DATA_WIDTH  saved PC to reload
// - halted_a_i     in   1           core A halted ack
// - halted_b_i     in   1           core B halted ack
// - debug_req_o    out  1           halt request, both cores
// - rf_we_o        out  1           register-file write enable, both cores
// - rf_addr_o      out  ADDR_WIDTH  register-file write address
// - rf_wdata_o     out  DATA_WIDTH  register-file write data
// - pc_we_o        out  1           PC load strobe
// - pc_o           out  DATA_WIDTH  PC load value
// - busy_o         out  1           high in any state but IDLE
// - done_o         out  1           1-cycle pulse on return to IDLE after successful recovery
// - wr_count_o     out  ADDR_WIDTH+1 registers written in current/last recovery
// - error_o        out  1           1-cycle pulse on watchdog abort (tied 0 without macro)
// BEHAVIOUR
// - Reset (rst_ni=0 at clk edge): state IDLE; every output 0; wr_count_o=0. Applies mid-recovery too:
//   debug_req_o drops next edge, no partial write/PC strobe issued after reset edge.
// - FSM IDLE -> HALT_REQ -> RESTORE -> PC_LOAD -> RELEASE -> IDLE.
// - IDLE: halt_i=1 -> HALT_REQ, wr_count_o cleared; shift_i/resume_i ignored.
// - HALT_REQ: debug_req_o=1; wait halted_a_i & halted_b_i both 1 (same cycle) -> RESTORE.
// - RESTORE: debug_req_o=1. shift_i=1 -> next cycle rf_we_o=1, rf_addr_o/rf_wdata_o=registered
//   addr_i/data_i (1-cycle latency), wr_count_o+1 (saturates at 2**ADDR_WIDTH).
//   addr_i=0 (x0): write suppressed (rf_we_o=0), count not incremented.
//   resume_i=1 -> PC_LOAD; a shift_i in the same cycle is still written.
//   wr_count_o reaching 2**ADDR_WIDTH-1 non-zero entries does NOT end RESTORE; only resume_i does.
// - PC_LOAD: exactly one cycle, pc_we_o=1, pc_o=spc_i sampled on RESTORE->PC_LOAD edge; rf_we_o=0.
// - RELEASE: debug_req_o=0; wait halted_a_i=0 & halted_b_i=0 -> IDLE with done_o=1 for one cycle.
// - halt_i asserted outside IDLE ignored; halt_i still high once IDLE reached starts new recovery.
// - pc_o, rf_addr_o, rf_wdata_o hold last value when strobes low; wr_count_o holds until next halt.
// - busy_o combinational from state; all other outputs registered.
// CONFIGURATION
// - FT_RECOVERY_TIMEOUT_EN defined: counter runs in HALT_REQ; at TIMEOUT_CYC cycles without both acks
//   -> error_o 1-cycle pulse, debug_req_o=0, state IDLE, no writes, no PC load, done_o stays 0.
// - Not defined: HALT_REQ waits indefinitely; error_o tied 0; no counter logic.
// TESTING
// - Reset: hold rst_ni=0 3 cycles with halt_i=1 -> all outputs 0, busy_o=0.
// - Full recovery: halt_i, acks after 2 cycles, shift 32 entries addr=i data=i*10, resume, spc_i=32'h80
//   -> 31 writes (x0 skipped), rf_wdata_o=i*10 one cycle after each shift, wr_count_o=31,
//   one pc_we_o with pc_o=32'h80, done_o after acks drop.
// - Early resume: 5 shifts (addr 1..5) then resume_i with a 6th shift same cycle -> 6 writes, PC_LOAD next.
// - Single ack: only halted_a_i=1 for 20 cycles -> stays HALT_REQ, no rf_we_o; then halted_b_i=1 -> RESTORE.
// - Mid-recovery reset: rst_ni=0 during RESTORE -> debug_req_o=0, rf_we_o=0 next edge, no pc_we_o.
// - Timeout (macro on, TIMEOUT_CYC=64): no acks -> error_o pulse at cycle 64 in HALT_REQ, back to IDLE.

Source files
------------

// File: rtl/ft_recovery_ctrl_if.sv
// ft_recovery_ctrl_if: recovery stream from the lockstep checker plus the
// core-side control bus driven by ft_recovery_ctrl.
// The slave modport belongs to the controller; master belongs to whoever
// drives the recovery stream and observes the core-side strobes.
interface ft_recovery_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 2**ADDR_WIDTH
);
    logic                  halt_i;
    logic                  shift_i;
    logic                  resume_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] spc_i;
    logic                  halted_a_i;
    logic                  halted_b_i;

    logic                  debug_req_o;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_addr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  pc_we_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  busy_o;
    logic                  done_o;
    logic [ADDR_WIDTH:0]   wr_count_o;
    logic                  error_o;

    modport slave (
        input  halt_i, shift_i, resume_i, addr_i, data_i, spc_i,
        input  halted_a_i, halted_b_i,
        output debug_req_o, rf_we_o, rf_addr_o, rf_wdata_o, pc_we_o, pc_o,
        output busy_o, done_o, wr_count_o, error_o
    );

    modport master (
        output halt_i, shift_i, resume_i, addr_i, data_i, spc_i,
        output halted_a_i, halted_b_i,
        input  debug_req_o, rf_we_o, rf_addr_o, rf_wdata_o, pc_we_o, pc_o,
        input  busy_o, done_o, wr_count_o, error_o
    );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// ft_recovery_ctrl: core-side responder to the lockstep checker's recovery
// sequence. Halts both cores, replays the saved register file into them,
// reloads the PC, then releases the cores.
// Optional halt-ack watchdog: define FT_RECOVERY_TIMEOUT_EN to abort a
// recovery whose cores never acknowledge the halt within TIMEOUT_CYC cycles.
// The cores stay halted through PC_LOAD and are released only in RELEASE.
module ft_recovery_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 2**ADDR_WIDTH,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    ft_recovery_ctrl_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(2**ADDR_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        HALT_REQ,
        RESTORE,
        PC_LOAD,
        RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic                  debugReq_q, debugReq_d;
    logic                  rfWe_q, rfWe_d;
    logic [ADDR_WIDTH-1:0] rfAddr_q, rfAddr_d;
    logic [DATA_WIDTH-1:0] rfWdata_q, rfWdata_d;
    logic                  pcWe_q, pcWe_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  done_q, done_d;
    logic [CW-1:0]         wrCount_q, wrCount_d;
    logic                  bothAcked;
    logic                  bothReleased;

`ifdef FT_RECOVERY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
`else
    // The watchdog limit only matters when the watchdog is built in.
    if (TIMEOUT_CYC < 1) begin : g_timeoutUnused
    end
`endif

    assign bothAcked    = bus.halted_a_i & bus.halted_b_i;
    assign bothReleased = ~bus.halted_a_i & ~bus.halted_b_i;

    // Next-state and registered-output decisions for the recovery sequence.
    always_comb begin
        state_d   = state_q;
        rfWe_d    = 1'b0;
        rfAddr_d  = rfAddr_q;
        rfWdata_d = rfWdata_q;
        pcWe_d    = 1'b0;
        pc_d      = pc_q;
        done_d    = 1'b0;
        wrCount_d = wrCount_q;
`ifdef FT_RECOVERY_TIMEOUT_EN
        tmo_d     = tmo_q;
        error_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.halt_i) begin
                    state_d   = HALT_REQ;
                    wrCount_d = '0;
`ifdef FT_RECOVERY_TIMEOUT_EN
                    tmo_d     = '0;
`endif
                end
            end
            HALT_REQ: begin
                if (bothAcked) begin
                    state_d = RESTORE;
                end
`ifdef FT_RECOVERY_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            RESTORE: begin
                if (bus.shift_i && (bus.addr_i != '0)) begin
                    rfWe_d    = 1'b1;
                    rfAddr_d  = bus.addr_i;
                    rfWdata_d = bus.data_i;
                    if (wrCount_q != COUNT_MAX) begin
                        wrCount_d = wrCount_q + CW'(1);
                    end
                end
                if (bus.resume_i) begin
                    state_d = PC_LOAD;
                    pcWe_d  = 1'b1;
                    pc_d    = bus.spc_i;
                end
            end
            PC_LOAD: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (bothReleased) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        debugReq_d = (state_d == HALT_REQ) || (state_d == RESTORE) || (state_d == PC_LOAD);
    end

    // State and output registers; reset clears everything including any pending strobe.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            debugReq_q <= 1'b0;
            rfWe_q     <= 1'b0;
            rfAddr_q   <= '0;
            rfWdata_q  <= '0;
            pcWe_q     <= 1'b0;
            pc_q       <= '0;
            done_q     <= 1'b0;
            wrCount_q  <= '0;
`ifdef FT_RECOVERY_TIMEOUT_EN
            tmo_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            debugReq_q <= debugReq_d;
            rfWe_q     <= rfWe_d;
            rfAddr_q   <= rfAddr_d;
            rfWdata_q  <= rfWdata_d;
            pcWe_q     <= pcWe_d;
            pc_q       <= pc_d;
            done_q     <= done_d;
            wrCount_q  <= wrCount_d;
`ifdef FT_RECOVERY_TIMEOUT_EN
            tmo_q      <= tmo_d;
            error_q    <= error_d;
`endif
        end
    end

    assign bus.debug_req_o = debugReq_q;
    assign bus.rf_we_o     = rfWe_q;
    assign bus.rf_addr_o   = rfAddr_q;
    assign bus.rf_wdata_o  = rfWdata_q;
    assign bus.pc_we_o     = pcWe_q;
    assign bus.pc_o        = pc_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = done_q;
    assign bus.wr_count_o  = wrCount_q;
`ifdef FT_RECOVERY_TIMEOUT_EN
    assign bus.error_o     = error_q;
`else
    assign bus.error_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// tb_ft_recovery_ctrl: directed recovery scenarios followed by randomized
// traffic, all compared every cycle against a behavioural model of the
// recovery sequence. Honours FT_RECOVERY_TIMEOUT_EN like the design.
module tb_ft_recovery_ctrl;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int TMO = 64;

    localparam int PH_IDLE    = 0;
    localparam int PH_WAITACK = 1;
    localparam int PH_STREAM  = 2;
    localparam int PH_PCLOAD  = 3;
    localparam int PH_RELEASE = 4;

    logic clk;
    logic rst_n;

    ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ft_recovery_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural expectations.
    int            mPhase    = PH_IDLE;
    int            mWaited   = 0;
    logic          expDebug  = 1'b0;
    logic          expWe     = 1'b0;
    logic [AW-1:0] expAddr   = '0;
    logic [DW-1:0] expData   = '0;
    logic          expPcWe   = 1'b0;
    logic [DW-1:0] expPc     = '0;
    logic          expDone   = 1'b0;
    logic          expErr    = 1'b0;
    int            expCount  = 0;

    // Pulse tallies seen on the DUT outputs.
    int weSeen   = 0;
    int pcSeen   = 0;
    int doneSeen = 0;
    int errSeen  = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic s, input logic r,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [DW-1:0] spc, input logic ha, input logic hb);
        @(posedge clk);
        #1;
        bus.halt_i     = h;
        bus.shift_i    = s;
        bus.resume_i   = r;
        bus.addr_i     = a;
        bus.data_i     = d;
        bus.spc_i      = spc;
        bus.halted_a_i = ha;
        bus.halted_b_i = hb;
    endtask

    task automatic idle(input int n, input logic ha, input logic hb);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, '0, '0, ha, hb);
    endtask

    // Model step: what a recovery responder must present after this clock edge.
    task automatic modelStep();
        if (!rst_n) begin
            mPhase = PH_IDLE; mWaited = 0;
            expWe = 0; expAddr = '0; expData = '0; expPcWe = 0; expPc = '0;
            expDone = 0; expErr = 0; expCount = 0;
        end else begin
            expWe = 0; expPcWe = 0; expDone = 0; expErr = 0;
            if (mPhase == PH_IDLE) begin
                if (bus.halt_i) begin
                    mPhase = PH_WAITACK; mWaited = 0; expCount = 0;
                end
            end else if (mPhase == PH_WAITACK) begin
                if (bus.halted_a_i && bus.halted_b_i) mPhase = PH_STREAM;
                else begin
                    mWaited++;
`ifdef FT_RECOVERY_TIMEOUT_EN
                    if (mWaited >= TMO) begin
                        mPhase = PH_IDLE; expErr = 1;
                    end
`endif
                end
            end else if (mPhase == PH_STREAM) begin
                if (bus.shift_i && bus.addr_i != 0) begin
                    expWe = 1; expAddr = bus.addr_i; expData = bus.data_i;
                    expCount = (expCount < 2**AW) ? expCount + 1 : expCount;
                end
                if (bus.resume_i) begin
                    mPhase = PH_PCLOAD; expPcWe = 1; expPc = bus.spc_i;
                end
            end else if (mPhase == PH_PCLOAD) begin
                mPhase = PH_RELEASE;
            end else begin
                if (!bus.halted_a_i && !bus.halted_b_i) begin
                    mPhase = PH_IDLE; expDone = 1;
                end
            end
        end
        expDebug = (mPhase == PH_WAITACK) || (mPhase == PH_STREAM) || (mPhase == PH_PCLOAD);
    endtask

    // Per-cycle compare: advance the model at each edge, check the DUT mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkOutput("debug_req_o", 64'(bus.debug_req_o), 64'(expDebug));
            checkOutput("rf_we_o",     64'(bus.rf_we_o),     64'(expWe));
            checkOutput("rf_addr_o",   64'(bus.rf_addr_o),   64'(expAddr));
            checkOutput("rf_wdata_o",  64'(bus.rf_wdata_o),  64'(expData));
            checkOutput("pc_we_o",     64'(bus.pc_we_o),     64'(expPcWe));
            checkOutput("pc_o",        64'(bus.pc_o),        64'(expPc));
            checkOutput("busy_o",      64'(bus.busy_o),      64'(mPhase != PH_IDLE));
            checkOutput("done_o",      64'(bus.done_o),      64'(expDone));
            checkOutput("wr_count_o",  64'(bus.wr_count_o),  64'(expCount));
            checkOutput("error_o",     64'(bus.error_o),     64'(expErr));
            if (bus.rf_we_o === 1'b1) weSeen++;
            if (bus.pc_we_o === 1'b1) pcSeen++;
            if (bus.done_o  === 1'b1) doneSeen++;
            if (bus.error_o === 1'b1) errSeen++;
        end
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        int we0, pc0, dn0, er0;
        rst_n = 1'b0;
        bus.halt_i = 0; bus.shift_i = 0; bus.resume_i = 0; bus.addr_i = '0;
        bus.data_i = '0; bus.spc_i = '0; bus.halted_a_i = 0; bus.halted_b_i = 0;

        // Reset held with halt_i high.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, '0, '0, 0, 0);
        @(negedge clk);
        checkOutput("reset debug_req", 64'(bus.debug_req_o), 64'd0);
        checkOutput("reset busy",      64'(bus.busy_o),      64'd0);
        checkOutput("reset wr_count",  64'(bus.wr_count_o),  64'd0);
        checkOutput("reset pc",        64'(bus.pc_o),        64'd0);
        rst_n = 1'b1;
        idle(2, 0, 0);

        // Full recovery with 32 shifted entries.
        $display("[TB] full recovery");
        we0 = weSeen; pc0 = pcSeen; dn0 = doneSeen;
        applyStimulus(1, 0, 0, '0, '0, '0, 0, 0);
        idle(2, 0, 0);
        idle(1, 1, 1);
        for (int i = 0; i < 32; i++) applyStimulus(0, 1, 0, AW'(i), DW'(i * 10), '0, 1, 1);
        applyStimulus(0, 0, 1, '0, '0, 32'h80, 1, 1);
        idle(3, 1, 1);
        idle(3, 0, 0);
        @(negedge clk);
        checkOutput("full writes",    64'(weSeen - we0),   64'd31);
        checkOutput("full pc_we",     64'(pcSeen - pc0),   64'd1);
        checkOutput("full done",      64'(doneSeen - dn0), 64'd1);
        checkOutput("full wr_count",  64'(bus.wr_count_o), 64'd31);
        checkOutput("full pc",        64'(bus.pc_o),        64'h80);
        checkOutput("full last data", 64'(bus.rf_wdata_o),  64'd310);

        // Early resume with a shift in the resume cycle.
        $display("[TB] early resume");
        we0 = weSeen;
        applyStimulus(1, 0, 0, '0, '0, '0, 1, 1);
        idle(1, 1, 1);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, AW'(i), $urandom, '0, 1, 1);
        applyStimulus(0, 1, 1, AW'(6), 32'hCAFE, 32'h1234, 1, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("early pc_we",   64'(bus.pc_we_o),   64'd1);
        checkOutput("early rf_addr", 64'(bus.rf_addr_o), 64'd6);
        idle(3, 0, 0);
        checkOutput("early writes",  64'(weSeen - we0),  64'd6);

        // Only one core acknowledges for 20 cycles.
        $display("[TB] single ack");
        we0 = weSeen;
        applyStimulus(1, 0, 0, '0, '0, '0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, AW'(3), 32'h55, '0, 1, 0);
        @(negedge clk);
        checkOutput("single busy",   64'(bus.busy_o),      64'd1);
        checkOutput("single writes", 64'(weSeen - we0),    64'd0);
        applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
        applyStimulus(0, 1, 1, AW'(9), 32'h99, 32'h40, 1, 1);
        idle(4, 0, 0);
        checkOutput("single writes after", 64'(weSeen - we0), 64'd1);

        // Count saturates with more writes than registers.
        $display("[TB] saturation");
        applyStimulus(1, 0, 0, '0, '0, '0, 1, 1);
        idle(1, 1, 1);
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 0, AW'((i % 31) + 1), DW'(i), '0, 1, 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("saturated count", 64'(bus.wr_count_o), 64'd32);
        applyStimulus(0, 0, 1, '0, '0, 32'h10, 1, 1);
        idle(3, 0, 0);

        // Reset in the middle of a restore.
        $display("[TB] mid-recovery reset");
        pc0 = pcSeen;
        applyStimulus(1, 0, 0, '0, '0, '0, 1, 1);
        idle(1, 1, 1);
        applyStimulus(0, 1, 0, AW'(4), 32'h44, '0, 1, 1);
        applyStimulus(0, 1, 1, AW'(7), 32'h77, 32'h200, 1, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset debug_req", 64'(bus.debug_req_o), 64'd0);
        checkOutput("midreset rf_we",     64'(bus.rf_we_o),     64'd0);
        checkOutput("midreset pc_we",     64'(pcSeen - pc0),    64'd0);
        rst_n = 1'b1;
        idle(2, 0, 0);

        // Nobody acknowledges the halt.
        $display("[TB] missing acks");
        er0 = errSeen;
        applyStimulus(1, 0, 0, '0, '0, '0, 0, 0);
        idle(70, 0, 0);
        @(negedge clk);
`ifdef FT_RECOVERY_TIMEOUT_EN
        checkOutput("timeout error", 64'(errSeen - er0), 64'd1);
        checkOutput("timeout busy",  64'(bus.busy_o),    64'd0);
`else
        checkOutput("no-timeout error", 64'(errSeen - er0), 64'd0);
        checkOutput("no-timeout busy",  64'(bus.busy_o),    64'd1);
        idle(1, 1, 1);
        applyStimulus(0, 0, 1, '0, '0, 32'h8, 1, 1);
        idle(3, 0, 0);
`endif

        // Randomized traffic; the per-cycle compare does the checking.
        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 9) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 19) == 0,
                          AW'($urandom),
                          $urandom,
                          $urandom,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1'b1;
        idle(4, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
